swap_stream: RTL and testbench
==============================

// Module: swap_stream
// PURPOSE
//   Registered, flow-controlled successor of the in-place FFT pair swapper.
//   - Carries LANES independent word pairs per beat and conditionally exchanges each pair.
//   - Swap control is either per-lane external or auto-generated from a beat counter,
//     giving the bank-alternation pattern of in-place FFT stages.
//   - Sits between the butterfly output and the dual-bank RAM write port.
//   - A 2-entry buffer decouples valid/ready on both sides.
// PARAMETERS
//   BW     32  width of one data word
//   LANES  1   number of word pairs per beat
//   CNT_W  16  width of the auto-mode beat counter; stride_log range is 0..CNT_W-1
// PORTS
//   clk          in   1         rising-edge clock
//   rst          in   1         synchronous, active-high reset
//   mode         in   1         0 = external swap (swap_en), 1 = auto swap (counter)
//   stride_log   in   $clog2(CNT_W)  auto mode: swap bit index into beat counter
//   in_valid     in   1         input beat valid
//   in_ready     out  1         input beat accepted when in_valid & in_ready
//   in_last      in   1         last beat of a frame; clears the beat counter
//   swap_en      in   LANES     per-lane swap request (mode 0); bit i -> lane i
//   in_data1     in   LANES*BW  first words; lane i = [i*BW +: BW]
//   in_data2     in   LANES*BW  second words; same packing
//   out_valid    out  1         output beat valid
//   out_ready    in   1         output beat consumed when out_valid & out_ready
//   out_last     out  1         in_last of the beat being presented
//   out_swapped  out  LANES     lanes that were exchanged in the presented beat
//   out_data1    out  LANES*BW  first words after conditional swap
//   out_data2    out  LANES*BW  second words after conditional swap
// BEHAVIOUR
//   Reset (rst=1 at a clock edge):
//   - Buffer emptied and beat_cnt cleared to 0.
//   - out_valid, out_last, out_swapped, out_data1 and out_data2 all 0.
//   - in_ready is forced to 0 while rst=1.
//   - Mid-operation reset discards buffered beats; nothing already in the buffer is emitted after reset.
//   Swap decision, fixed at acceptance:
//   - mode=0: sw[i] = swap_en[i].
//   - mode=1: sw[i] = beat_cnt[stride_log] for all lanes.
//   - Lane i: sw[i]=1 gives out1=in2, out2=in1. sw[i]=0 passes in1 and in2 through.
//   - mode, stride_log and swap_en are sampled only on accepted beats. A change takes effect
//     on the next accepted beat, including mid-frame.
//   beat_cnt:
//   - Increments by 1 on each accepted beat, in both modes.
//   - Wraps modulo 2^CNT_W.
//   - An accepted beat with in_last=1 uses the current count, then loads 0.
//   Buffer: 2-entry FIFO of {last, swapped, data1, data2}; outputs come straight from the head register.
//   - count=0: out_valid=0. count 1 or 2: out_valid=1.
//   - in_ready = ~rst & (count<2). It is registered; there is no combinational path from out_ready.
//   - Push and pop in the same cycle: count unchanged. Order is strictly FIFO.
//   Latency and throughput:
//   - Accept at edge t with an empty buffer: out_valid=1 from after edge t, i.e. the beat is
//     presented in the next cycle.
//   - Sustained throughput is 1 beat/cycle while out_ready=1.
//   Stall: while out_valid=1 and out_ready=0, all out_* hold stable.
//   Output data: when out_valid=0, out_data holds its last value. Only out_valid is meaningful then.
// TESTING
//   1 Reset: drive rst for 2 cycles with in_valid=1.
//     -> in_ready=0, out_valid=0, all outputs 0.
//     -> After release: in_ready=1, no output beat appears.
//   2 External swap, LANES=2, BW=32, mode=0: one beat with swap_en=2'b10,
//     in_data1={B1,A1}, in_data2={B2,A2}.
//     -> Next cycle: out_data1={B2,A1}, out_data2={B1,A2}, out_swapped=2'b10.
//   3 Auto mode, stride_log=1: 8 back-to-back beats, out_ready=1.
//     -> out_swapped per beat = 0,0,1,1,0,0,1,1.
//     -> One output per cycle with 1-cycle latency.
//   4 Frame restart, auto mode, stride_log=0: 3 beats, the third with in_last=1, then 2 more beats.
//     -> out_swapped = 0,1,0,0,1; out_last=1 only on the third beat.
//   5 Backpressure: out_ready=0 while 3 beats are offered.
//     -> in_ready drops to 0 after 2 accepted beats; outputs hold.
//     -> Raise out_ready: both beats emerge in order, then the third is accepted. No loss, no duplicates.
//   6 Reset mid-stream with 2 beats buffered.
//     -> out_valid=0 on the cycle after the reset edge; the buffered beats never appear.
//     -> beat_cnt restarts at 0, so the first auto-mode beat afterwards has swapped=0.

Source files
------------

// File: rtl/swap_stream.sv
// swap_stream: registered, flow-controlled conditional pair swapper with a 2-entry output FIFO.
module swap_stream #(
    parameter int BW    = 32,
    parameter int LANES = 1,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [$clog2(CNT_W)-1:0] stride_log,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [LANES-1:0]         swap_en,
    input  logic [LANES*BW-1:0]      in_data1,
    input  logic [LANES*BW-1:0]      in_data2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [LANES-1:0]         out_swapped,
    output logic [LANES*BW-1:0]      out_data1,
    output logic [LANES*BW-1:0]      out_data2
);
    localparam int DW = LANES * BW;
    localparam int EW = 1 + LANES + 2 * DW;

    logic [1:0]       count;
    logic [EW-1:0]    head, tail, entry;
    logic [CNT_W-1:0] beat_cnt;
    logic [LANES-1:0] sw;
    logic [DW-1:0]    d1, d2;
    logic             push, pop;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = ~rst & ~count[1];
    assign out_valid = |count;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign sw        = mode ? {LANES{beat_cnt[stride_log]}} : swap_en;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign d1[i*BW +: BW] = sw[i] ? in_data2[i*BW +: BW] : in_data1[i*BW +: BW];
        assign d2[i*BW +: BW] = sw[i] ? in_data1[i*BW +: BW] : in_data2[i*BW +: BW];
    end

    assign entry = {in_last, sw, d1, d2};
    assign {out_last, out_swapped, out_data1, out_data2} = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            beat_cnt <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop && count == 2'd2)
                head <= tail;
            else if (push && (count == 2'd0 || (count == 2'd1 && pop)))
                head <= entry;
            if (push && count == 2'd1 && !pop)
                tail <= entry;
            if (push)
                beat_cnt <= in_last ? '0 : beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_swap_stream.sv
// tb_swap_stream: directed self-checking bench for swap_stream with LANES=2, BW=32.
module tb_swap_stream;
    logic        clk = 1'b0;
    logic        rst, mode, in_valid, in_last, out_ready;
    logic [3:0]  stride_log;
    logic [1:0]  swap_en;
    logic [63:0] in_data1, in_data2;
    logic        in_ready, out_valid, out_last;
    logic [1:0]  out_swapped;
    logic [63:0] out_data1, out_data2;
    int          checks = 0;
    int          failures = 0;

    swap_stream #(.BW(32), .LANES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .stride_log(stride_log),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .swap_en(swap_en), .in_data1(in_data1), .in_data2(in_data2),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_swapped(out_swapped), .out_data1(out_data1), .out_data2(out_data2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic last, input logic [1:0] swp,
                            input logic [63:0] e1, input logic [63:0] e2);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_last"}, {63'd0, out_last}, {63'd0, last});
        chk({tag, "_swapped"}, {62'd0, out_swapped}, {62'd0, swp});
        chk({tag, "_d1"}, out_data1, e1);
        chk({tag, "_d2"}, out_data2, e2);
    endtask

    initial begin
        logic [63:0] a, b;
        logic [1:0]  exp_sw;
        logic        exp_last;
        rst = 1'b1; mode = 1'b0; stride_log = 4'd0; in_valid = 1'b1; in_last = 1'b0;
        swap_en = 2'b11; in_data1 = 64'h1111_1111_2222_2222; in_data2 = 64'h3333_3333_4444_4444;
        out_ready = 1'b1;
        // 1: reset with in_valid asserted
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_outs", {out_last, out_swapped}, 64'd0);
            chk("rst_d1", out_data1, 64'd0);
            chk("rst_d2", out_data2, 64'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("rel_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rel_in_ready2", {63'd0, in_ready}, 64'd1);
        // 2: external swap on lane 1 only; in_last also clears beat_cnt
        swap_en = 2'b10; in_last = 1'b1; in_valid = 1'b1;
        in_data1 = {32'hB1B1_B1B1, 32'hA1A1_A1A1};
        in_data2 = {32'hB2B2_B2B2, 32'hA2A2_A2A2};
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk_beat("ext", 1'b1, 2'b10, {32'hB2B2_B2B2, 32'hA1A1_A1A1}, {32'hB1B1_B1B1, 32'hA2A2_A2A2});
        step();
        chk("ext_drain", {63'd0, out_valid}, 64'd0);
        // 3: auto mode, stride_log=1, 8 back-to-back beats
        mode = 1'b1; stride_log = 4'd1; swap_en = 2'b00; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = {32'(k + 32'h100), 32'(k)};
            b = {32'(k + 32'h300), 32'(k + 32'h200)};
            in_data1 = a; in_data2 = b; in_last = (k == 7);
            exp_sw = (k % 4 >= 2) ? 2'b11 : 2'b00;
            step();
            chk_beat("auto", k == 7, exp_sw, exp_sw[0] ? b : a, exp_sw[0] ? a : b);
        end
        in_valid = 1'b0; in_last = 1'b0;
        step();
        chk("auto_drain", {63'd0, out_valid}, 64'd0);
        // 4: frame restart, stride_log=0
        stride_log = 4'd0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a = {32'(k + 32'h500), 32'(k + 32'h400)};
            b = {32'(k + 32'h700), 32'(k + 32'h600)};
            in_data1 = a; in_data2 = b; in_last = (k == 2);
            exp_sw = (k == 1 || k == 4) ? 2'b11 : 2'b00;
            exp_last = (k == 2);
            step();
            chk_beat("frame", exp_last, exp_sw, exp_sw[0] ? b : a, exp_sw[0] ? a : b);
        end
        in_valid = 1'b0; in_last = 1'b0;
        step();
        chk("frame_drain", {63'd0, out_valid}, 64'd0);
        // 5: backpressure, external mode swapping lane 0
        mode = 1'b0; swap_en = 2'b01; out_ready = 1'b0; in_valid = 1'b1;
        in_data1 = {32'hAAAA_0001, 32'hAAAA_0000}; in_data2 = {32'hAAAA_0003, 32'hAAAA_0002};
        step();
        chk("bp_rdy1", {63'd0, in_ready}, 64'd1);
        chk_beat("bp_a", 1'b0, 2'b01, 64'hAAAA_0001_AAAA_0002, 64'hAAAA_0003_AAAA_0000);
        in_data1 = {32'hBBBB_0001, 32'hBBBB_0000}; in_data2 = {32'hBBBB_0003, 32'hBBBB_0002};
        step();
        chk("bp_rdy2", {63'd0, in_ready}, 64'd0);
        chk_beat("bp_hold1", 1'b0, 2'b01, 64'hAAAA_0001_AAAA_0002, 64'hAAAA_0003_AAAA_0000);
        in_data1 = {32'hCCCC_0001, 32'hCCCC_0000}; in_data2 = {32'hCCCC_0003, 32'hCCCC_0002};
        step();
        chk("bp_rdy3", {63'd0, in_ready}, 64'd0);
        chk_beat("bp_hold2", 1'b0, 2'b01, 64'hAAAA_0001_AAAA_0002, 64'hAAAA_0003_AAAA_0000);
        out_ready = 1'b1;
        step();
        chk("bp_rdy4", {63'd0, in_ready}, 64'd1);
        chk_beat("bp_b", 1'b0, 2'b01, 64'hBBBB_0001_BBBB_0002, 64'hBBBB_0003_BBBB_0000);
        step();
        in_valid = 1'b0;
        chk_beat("bp_c", 1'b0, 2'b01, 64'hCCCC_0001_CCCC_0002, 64'hCCCC_0003_CCCC_0000);
        step();
        chk("bp_drain", {63'd0, out_valid}, 64'd0);
        // 6: reset with two beats buffered (beat_cnt is nonzero here)
        mode = 1'b1; stride_log = 4'd0; out_ready = 1'b0; in_valid = 1'b1;
        in_data1 = 64'hDEAD_0001_DEAD_0000; in_data2 = 64'hDEAD_0003_DEAD_0002;
        step();
        step();
        chk("mid_full", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        in_data1 = 64'h5555_0001_5555_0000; in_data2 = 64'h5555_0003_5555_0002;
        step();
        chk_beat("post0", 1'b0, 2'b00, 64'h5555_0001_5555_0000, 64'h5555_0003_5555_0002);
        step();
        in_valid = 1'b0;
        chk_beat("post1", 1'b0, 2'b11, 64'h5555_0003_5555_0002, 64'h5555_0001_5555_0000);
        step();
        chk("post_drain", {63'd0, out_valid}, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
